fifo_nl_wrapper: RTL and testbench

//  Synchronous single-clock FIFO for 32-bit words; wrapper around a RAM-style storage core.

---
 rtl/fifo_nl_pkg.sv | 14 +
 rtl/fifo_nl_if.sv | 33 +++
 rtl/fifo_nl_core.sv | 69 ++++++
 rtl/fifo_nl_wrapper.sv | 60 ++++++
 tb/tb_fifo_nl_wrapper.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fifo_nl_pkg.sv
// Shared defaults and derived sizing for the fifo_nl FIFO slice.
package fifo_nl_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_LOG2_DEF = 4;

  function automatic int depth_of(input int log2);
    return 1 << log2;
  endfunction

  localparam int DEPTH_DEF = depth_of(DEPTH_LOG2_DEF);
  localparam int PTR_W_DEF = DEPTH_LOG2_DEF + 1;

endpackage

// File: rtl/fifo_nl_if.sv
// Producer/consumer handshake bundle for the fifo_nl FIFO.
interface fifo_nl_if
  import fifo_nl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  wr;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;
  logic                  rd;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty;

  modport master (
    output wr,
    output din,
    output rd,
    input  full,
    input  empty,
    input  dout
  );

  modport slave (
    input  wr,
    input  din,
    input  rd,
    output full,
    output empty,
    output dout
  );

endinterface

// File: rtl/fifo_nl_core.sv
// Storage array, wrap-bit pointers, registered flags and registered read port.
module fifo_nl_core
  import fifo_nl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  rd_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] dout_o
);

  localparam int DEPTH = depth_of(DEPTH_LOG2);
  localparam int PTR_W = DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_en, rd_en;

  // Flags derive from the post-edge pointers so they settle in the same edge.
  always_comb begin
    wr_en    = wr_i && !full_q;
    rd_en    = rd_i && !empty_q;
    wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, rd_en};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
               (wr_ptr_d[PTR_W-2:0] == rd_ptr_d[PTR_W-2:0]);
    dout_d   = rd_en ? mem_q[rd_ptr_q[PTR_W-2:0]] : dout_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is deliberately left out of reset; stale words are unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[PTR_W-2:0]] <= din_i;
    end
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign dout_o  = dout_q;

endmodule

// File: rtl/fifo_nl_wrapper.sv
// FIFO top: non-lookahead by default; define FIFO_LOOKAHEAD_EN for first-word-fall-through.
module fifo_nl_wrapper
  import fifo_nl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic      clk,
  input  logic      rst,
  fifo_nl_if.slave  bus
);

  logic                  core_rd;
  logic                  core_full;
  logic                  core_empty;
  logic [DATA_WIDTH-1:0] core_dout;

  fifo_nl_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (bus.wr),
    .din_i   (bus.din),
    .rd_i    (core_rd),
    .full_o  (core_full),
    .empty_o (core_empty),
    .dout_o  (core_dout)
  );

`ifdef FIFO_LOOKAHEAD_EN
  // The core's registered read port acts as the output register; ovld_q marks it occupied.
  logic ovld_q, ovld_d;
  logic pop;

  always_comb begin
    pop     = bus.rd && ovld_q;
    core_rd = !core_empty && (!ovld_q || pop);
    ovld_d  = core_rd ? 1'b1 : (pop ? 1'b0 : ovld_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovld_q <= 1'b0;
    end else begin
      ovld_q <= ovld_d;
    end
  end

  assign bus.empty = !ovld_q;
`else
  assign core_rd   = bus.rd;
  assign bus.empty = core_empty;
`endif

  assign bus.full = core_full;
  assign bus.dout = core_dout;

endmodule

// File: tb/tb_fifo_nl_wrapper.sv
// Scoreboard bench for fifo_nl_wrapper in its default non-lookahead build.
module tb_fifo_nl_wrapper;

  logic clk = 1'b0;
  logic rst;

  fifo_nl_if #(.DATA_WIDTH(32)) bus ();

  fifo_nl_wrapper #(.DATA_WIDTH(32), .DEPTH_LOG2(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_dout;
  string       tname;
  logic [7:0]  bytes_t [8] = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};

  // Check outputs settled after the previous edge, drive the next cycle, update the model.
  task automatic step(input logic w, input logic [31:0] d, input logic r);
    int   n;
    logic exp_empty, exp_full, racc, wacc;
    n         = sb.size();
    exp_empty = (n == 0);
    exp_full  = (n == 16);
    compared++;
    if (bus.empty !== exp_empty) begin
      mismatched++;
      $display("FAIL %s empty: got %b expected %b", tname, bus.empty, exp_empty);
    end
    compared++;
    if (bus.full !== exp_full) begin
      mismatched++;
      $display("FAIL %s full: got %b expected %b", tname, bus.full, exp_full);
    end
    compared++;
    if (bus.dout !== exp_dout) begin
      mismatched++;
      $display("FAIL %s dout: got %h expected %h", tname, bus.dout, exp_dout);
    end
    racc    = r && !exp_empty;
    wacc    = w && !exp_full;
    bus.wr  = w;
    bus.din = d;
    bus.rd  = r;
    if (racc) exp_dout = sb.pop_front();
    if (wacc) sb.push_back(d);
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && sb.size() > 0; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL %s drain: %0d words left, expected 0", tname, sb.size());
    end
  endtask

  task automatic check_reset_outputs();
    compared++;
    if (bus.empty !== 1'b1) begin
      mismatched++;
      $display("FAIL %s reset empty: got %b expected 1", tname, bus.empty);
    end
    compared++;
    if (bus.full !== 1'b0) begin
      mismatched++;
      $display("FAIL %s reset full: got %b expected 0", tname, bus.full);
    end
    compared++;
    if (bus.dout !== 32'h0) begin
      mismatched++;
      $display("FAIL %s reset dout: got %h expected 0", tname, bus.dout);
    end
  endtask

  task automatic test_reset();
    tname   = "reset";
    rst     = 1'b0;
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
    bus.din = 32'h0;
    #12;
    check_reset_outputs();
    sb.delete();
    exp_dout = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_stream();
    tname = "stream";
    for (int i = 0; i < 8; i++) begin
      step(1'b1, {24'h0, bytes_t[i]}, 1'($urandom_range(0, 1)));
    end
    drain(20);
  endtask

  task automatic test_fill();
    tname = "fill";
    for (int i = 0; i < 16; i++) step(1'b1, 32'h1000_0000 + 32'(i * 17), 1'b0);
    step(1'b1, 32'h0000_00FF, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    drain(20);
  endtask

  task automatic test_empty_read();
    tname = "empty_read";
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hABCD_1234, 1'b0);
    drain(4);
  endtask

  task automatic test_concurrent();
    tname = "concurrent";
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_0C00 + 32'(i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h0000_0D00 + 32'(i), 1'b1);
    drain(8);
  endtask

  task automatic test_reset_mid();
    tname = "reset_mid";
    step(1'b1, 32'h0000_0011, 1'b0);
    step(1'b1, 32'h0000_0022, 1'b0);
    step(1'b1, 32'h0000_0033, 1'b0);
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    exp_dout = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 32'h0000_007A, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    compared++;
    if (bus.dout !== 32'h0000_007A) begin
      mismatched++;
      $display("FAIL %s first word: got %h expected 0000007a", tname, bus.dout);
    end
  endtask

  initial begin
    exp_dout = 32'h0;
    test_reset();
    test_stream();
    test_fill();
    test_empty_read();
    test_concurrent();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
